// File: rtl/processor_core_if.sv
// Observation/load bus of the teaching core: program load port, run control and exported state.
// The bench/top side is the master; the core is the slave.
interface processor_core_if;
   logic [31:0] addr;
   logic        wr;
   logic [31:0] wdata;
   logic        working;
   logic [3:0]  rID;
   logic [31:0] valE;
   logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [31:0] rdata;
   logic [2:0]  cc;

   modport master (
      output addr, wr, wdata, working, rID,
      input  valE, r0, r1, r2, r3, r4, r5, r6, r7, rdata, cc
   );

   modport slave (
      input  addr, wr, wdata, working, rID,
      output valE, r0, r1, r2, r3, r4, r5, r6, r7, rdata, cc
   );
endinterface

// File: rtl/processor_core.sv
// Single-cycle Y86-style core: combinational fetch/decode/execute from imem[PC], commit on the edge.
// One instruction per clock while working=1; no backpressure, HALT parks the PC until working drops.
module processor_core #(
   parameter int IMEM_AW = 8
) (
   input  logic              clock,
   input  logic              rst_n,
   processor_core_if.slave   bus
);
   typedef enum logic {S_RUN, S_HALT} state_t;

   localparam logic [IMEM_AW-1:0] PC_ONE = 1;

   logic [31:0]        imem [2**IMEM_AW];
   logic [31:0]        regs_q [8];
   logic [IMEM_AW-1:0] pc_q, pc_d;
   state_t             state_q, state_d;
   logic [2:0]         cc_q, cc_d;

   logic [31:0] instr, val_a, val_b, val_e;
   logic [3:0]  icode, ifun, ra, rb;
   logic [15:0] valc;
   logic        is_halt, wr_req, cc_req, of_flag, commit, rf_we;

   // imem has no reset: the program survives a core reset
   always_ff @(posedge clock) begin
      if (bus.wr) imem[bus.addr[IMEM_AW-1:0]] <= bus.wdata;
   end

   assign instr = imem[pc_q];
   assign icode = instr[31:28];
   assign ifun  = instr[27:24];
   assign ra    = instr[23:20];
   assign rb    = instr[19:16];
   assign valc  = instr[15:0];
   assign val_a = (ra < 4'd8) ? regs_q[ra[2:0]] : 32'd0;
   assign val_b = (rb < 4'd8) ? regs_q[rb[2:0]] : 32'd0;

   always_comb begin
      val_e   = 32'd0;
      is_halt = 1'b0;
      wr_req  = 1'b0;
      cc_req  = 1'b0;
      of_flag = 1'b0;
      case (icode)
         4'h0: is_halt = 1'b1;
         4'h1: begin
            val_e  = {16'b0, valc};
            wr_req = 1'b1;
         end
         4'h2: begin
            case (ifun)
               4'h0: begin
                  val_e   = val_b + val_a;
                  of_flag = (val_b[31] == val_a[31]) && (val_e[31] != val_b[31]);
               end
               4'h1: begin
                  val_e   = val_b - val_a;
                  of_flag = (val_b[31] != val_a[31]) && (val_e[31] != val_b[31]);
               end
               4'h2: val_e = val_b & val_a;
               4'h3: val_e = val_b ^ val_a;
               default: val_e = 32'd0;
            endcase
            wr_req = (ifun < 4'd4);
            cc_req = (ifun < 4'd4);
         end
         4'h3: begin
            val_e  = val_a;
            wr_req = 1'b1;
         end
         default: val_e = 32'd0;
      endcase
   end

   assign commit = bus.working && (state_q == S_RUN);
   assign rf_we  = commit && wr_req && (rb < 4'd8);

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      cc_d    = cc_q;
      if (!bus.working) begin
         pc_d    = '0;
         state_d = S_RUN;
      end else if (state_q == S_RUN) begin
         if (is_halt) state_d = S_HALT;
         else         pc_d    = pc_q + PC_ONE;
         if (cc_req)  cc_d    = {(val_e == 32'd0), val_e[31], of_flag};
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         state_q <= S_RUN;
         cc_q    <= 3'b000;
         for (int i = 0; i < 8; i++) regs_q[i] <= 32'd0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         cc_q    <= cc_d;
         if (rf_we) regs_q[rb[2:0]] <= val_e;
      end
   end

   assign bus.valE  = val_e;
   assign bus.cc    = cc_q;
   assign bus.r0    = regs_q[0];
   assign bus.r1    = regs_q[1];
   assign bus.r2    = regs_q[2];
   assign bus.r3    = regs_q[3];
   assign bus.r4    = regs_q[4];
   assign bus.r5    = regs_q[5];
   assign bus.r6    = regs_q[6];
   assign bus.r7    = regs_q[7];
   assign bus.rdata = bus.working ? ((bus.rID < 4'd8) ? regs_q[bus.rID[2:0]] : 32'd0)
                                  : imem[bus.addr[IMEM_AW-1:0]];

   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.addr[31:IMEM_AW];
endmodule

// File: tb/tb_processor_core.sv
// Directed bench for processor_core: expectations queued as each step is driven, popped at each observation.
module tb_processor_core;
   logic clock = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_q[$];

   processor_core_if bus();

   processor_core #(.IMEM_AW(8)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic expect_val(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: observed %h but scoreboard empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.wr    = 1'b1;
      tick(1);
      bus.wr    = 1'b0;
   endtask

   logic [31:0] prog1 [6];
   logic [31:0] ovf [22];

   initial begin
      prog1 = '{32'h10f00010, 32'h20010000, 32'h21230000, 32'h22450000, 32'h23670000, 32'h00000000};
      ovf[0] = 32'h10F3FFFF;
      ovf[1] = 32'h10F47FFF;
      for (int i = 2; i < 18; i++) ovf[i] = 32'h20440000;
      ovf[18] = 32'h20340000;
      ovf[19] = 32'h10F50001;
      ovf[20] = 32'h20540000;
      ovf[21] = 32'h00000000;

      bus.addr = 32'd0; bus.wr = 1'b0; bus.wdata = 32'd0; bus.working = 1'b0; bus.rID = 4'd0;

      // reset state
      #3;
      expect_val(32'd0); check("reset_r0", bus.r0);
      expect_val(32'd0); check("reset_r7", bus.r7);
      expect_val(32'd0); check("reset_cc", {29'd0, bus.cc});
      rst_n = 1'b1;

      // program 1
      for (int i = 0; i < 6; i++) load(i, prog1[i]);
      bus.addr = 32'd0; #1;
      expect_val(32'h10f00010); check("idle_rdata_imem0", bus.rdata);
      expect_val(32'h00000010); check("valE_pc0", bus.valE);
      bus.working = 1'b1; bus.rID = 4'd0; #1;
      expect_val(32'd0); check("rdata_old_before_edge", bus.rdata);
      tick(6);
      expect_val(32'h10); check("p1_r0", bus.r0);
      expect_val(32'h10); check("p1_r1", bus.r1);
      expect_val(32'h0);  check("p1_r3", bus.r3);
      expect_val(32'h0);  check("p1_r5", bus.r5);
      expect_val(32'h0);  check("p1_r7", bus.r7);
      expect_val(32'h4);  check("p1_cc", {29'd0, bus.cc});
      tick(3);
      expect_val(32'h10); check("halted_r1_stable", bus.r1);

      // rID observation
      bus.rID = 4'd1; #1;
      expect_val(32'h10); check("rid1", bus.rdata);
      bus.rID = 4'hF; #1;
      expect_val(32'h0); check("ridF", bus.rdata);

      // halt/restart: program re-runs, r1 accumulates r0 again
      bus.working = 1'b0; tick(1);
      bus.working = 1'b1; tick(6);
      expect_val(32'h20); check("restart_r1", bus.r1);
      expect_val(32'h10); check("restart_r0", bus.r0);
      expect_val(32'h4);  check("restart_cc", {29'd0, bus.cc});

      // reset mid-run
      bus.working = 1'b0; tick(1);
      bus.working = 1'b1; tick(2);
      expect_val(32'h30); check("midrun_r1", bus.r1);
      #2 rst_n = 1'b0; #1;
      expect_val(32'h0);  check("arst_r0", bus.r0);
      expect_val(32'h0);  check("arst_r1", bus.r1);
      expect_val(32'h0);  check("arst_cc", {29'd0, bus.cc});
      expect_val(32'h10); check("arst_valE_imem_kept", bus.valE);
      #1 rst_n = 1'b1;
      tick(6);
      expect_val(32'h10); check("post_rst_r0", bus.r0);
      expect_val(32'h10); check("post_rst_r1", bus.r1);

      // readback
      bus.working = 1'b0;
      load(32'd2, 32'hDEADBEEF);
      bus.addr = 32'd2; #1;
      expect_val(32'hDEADBEEF); check("readback", bus.rdata);

      // sub and flags
      load(32'd0, 32'h10F10005);
      load(32'd1, 32'h10F20007);
      load(32'd2, 32'h21210000);
      load(32'd3, 32'h00000000);
      bus.working = 1'b1; tick(4);
      expect_val(32'hFFFFFFFE); check("sub_r1", bus.r1);
      expect_val(32'h7);        check("sub_r2", bus.r2);
      expect_val(32'h2);        check("sub_cc", {29'd0, bus.cc});
      bus.rID = 4'd1; #1;
      expect_val(32'hFFFFFFFE); check("sub_rdata_rid1", bus.rdata);

      // add overflow: build 0x7FFFFFFF then add 1
      bus.working = 1'b0;
      for (int i = 0; i < 22; i++) load(i, ovf[i]);
      bus.working = 1'b1; tick(22);
      expect_val(32'h0000FFFF); check("ovf_r3", bus.r3);
      expect_val(32'h80000000); check("ovf_r4", bus.r4);
      expect_val(32'h3);        check("ovf_cc", {29'd0, bus.cc});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
